// File: rtl/arbiter_word_packer.sv
// Packs the arbiter's byte stream little-endian into 32-bit words presented on a
// ready/valid port; partial words are closed by flush, and bytes with no free storage are dropped.
module arbiter_word_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [3:0]       out_keep,
    output logic             overflow,
    output logic [CNT_W-1:0] words_sent
);

    // Handshake: a word moves when out_valid && out_ready at a rising edge; while
    // out_valid && !out_ready, out_data/out_keep hold. The input side has no ready.
    logic [31:0] asm_q, asm_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        overflow_d;
    logic        slot_free;
    logic        full_xfer;
    logic        flush_xfer;
    logic        xfer;
    logic        handshake;
    logic [3:0]  keep_new;

    always_comb begin
        slot_free  = !out_valid || out_ready;
        handshake  = out_valid && out_ready;
        full_xfer  = slot_free && (cnt_q == 3'd4);
        flush_xfer = slot_free && flush && !in_valid && (cnt_q != 3'd0) && (cnt_q != 3'd4);
        xfer       = full_xfer || flush_xfer;

        case (cnt_q)
            3'd1:    keep_new = 4'b0001;
            3'd2:    keep_new = 4'b0011;
            3'd3:    keep_new = 4'b0111;
            default: keep_new = 4'b1111;
        endcase

        asm_d      = asm_q;
        cnt_d      = cnt_q;
        overflow_d = overflow;

        if (xfer) begin
            asm_d = 32'd0;
            cnt_d = 3'd0;
        end

        // A flush transfer never coincides with a byte, so lane writes below cannot collide with it.
        if (in_valid) begin
            if (cnt_q < 3'd4) begin
                asm_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
                cnt_d = cnt_q + 3'd1;
            end else if (xfer) begin
                asm_d = {24'd0, in_data};
                cnt_d = 3'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= 32'd0;
            cnt_q      <= 3'd0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_keep   <= 4'd0;
            words_sent <= '0;
        end else begin
            asm_q    <= asm_d;
            cnt_q    <= cnt_d;
            overflow <= overflow_d;
            // Unfilled lanes of asm_q are already zero: it is cleared on every transfer.
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= asm_q;
                out_keep  <= keep_new;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (handshake) begin
                words_sent <= words_sent + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_word_packer.sv
// Bench for arbiter_word_packer: directed scenarios plus random traffic, checked
// against a queue-based byte/word model and a scoreboard of expected words.
module tb_arbiter_word_packer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          overflow;
    logic [CW-1:0] words_sent;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]    m_bytes[$];
    logic          m_valid = 1'b0;
    logic [31:0]   m_data  = 32'd0;
    logic [3:0]    m_keep  = 4'd0;
    logic          m_ovf   = 1'b0;
    logic [CW-1:0] m_ws    = '0;

    logic [31:0]   exp_q[$];

    arbiter_word_packer #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .overflow   (overflow),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, phrased as byte queue and word slot.
    task automatic model_edge(input logic iv, input logic [7:0] d, input logic fl,
                              input logic rdy, input logic rs);
        logic        free;
        logic        xfer;
        logic        hs;
        logic [31:0] word;
        if (rs) begin
            m_bytes.delete();
            m_valid = 1'b0;
            m_data  = 32'd0;
            m_keep  = 4'd0;
            m_ovf   = 1'b0;
            m_ws    = '0;
            return;
        end
        free = !m_valid || rdy;
        hs   = m_valid && rdy;
        xfer = free && (m_bytes.size() == 4 || (fl && !iv && m_bytes.size() > 0));
        if (hs) m_ws = m_ws + 1'b1;
        if (xfer) begin
            word = 32'd0;
            for (int k = 0; k < m_bytes.size(); k++) word |= 32'(m_bytes[k]) << (8 * k);
            m_data  = word;
            m_keep  = 4'((1 << m_bytes.size()) - 1);
            m_valid = 1'b1;
            m_bytes.delete();
        end else if (hs) begin
            m_valid = 1'b0;
        end
        if (iv) begin
            if (m_bytes.size() < 4) m_bytes.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic cycle(input logic iv, input logic [7:0] d, input logic fl,
                         input logic rdy, input logic rs);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = rdy;
        rst       = rs;
        if (out_valid && rdy && !rs && exp_q.size() > 0) begin
            chk("sb_word", out_data, exp_q.pop_front());
        end
        @(posedge clk);
        model_edge(iv, d, fl, rdy, rs);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("words_sent", 32'(words_sent), 32'(m_ws));
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_keep", {28'd0, out_keep}, {28'd0, m_keep});
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_keep", {28'd0, out_keep}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_words_sent", 32'(words_sent), 32'd0);

        // Full word
        exp_q.push_back(32'h44332211);
        cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
        idle(1, 1'b1);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", out_data, 32'h44332211);
        chk("t1_keep", {28'd0, out_keep}, 32'hF);
        idle(2, 1'b1);
        chk("t1_words", 32'(words_sent), 32'd1);
        chk("t1_ovf", {31'd0, overflow}, 32'd0);

        // Flush of a three-byte word, then a full word
        do_reset();
        exp_q.push_back(32'h00CCBBAA);
        exp_q.push_back(32'h04030201);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t2_flush_keep", {28'd0, out_keep}, 32'h7);
        chk("t2_flush_data", out_data, 32'h00CCBBAA);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("t2_full_keep", {28'd0, out_keep}, 32'hF);
        idle(2, 1'b1);

        // Back-pressure: 8 bytes stored, ninth dropped
        do_reset();
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        for (int i = 1; i <= 9; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("t3_slot", out_data, 32'h04030201);
        chk("t3_ovf", {31'd0, overflow}, 32'd1);
        idle(4, 1'b1);
        chk("t3_words", 32'(words_sent), 32'd2);
        chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Lossless stream, byte 05 lands during the transfer edge
        do_reset();
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        chk("t4_words", 32'(words_sent), 32'd2);
        chk("t4_ovf", {31'd0, overflow}, 32'd0);

        // Reset mid-word discards contents
        do_reset();
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        do_reset();
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_data", out_data, 32'd0);
        exp_q.push_back(32'h40302010);
        cycle(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("t5_data", out_data, 32'h40302010);
        idle(2, 1'b1);

        // Flush ignored while a byte arrives
        do_reset();
        exp_q.push_back(32'h00557766);
        cycle(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        chk("t6_no_word", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t6_keep", {28'd0, out_keep}, 32'h7);
        chk("t6_lane2", {24'd0, out_data[23:16]}, 32'h55);
        idle(2, 1'b1);

        // words_sent wraps after 2^CW handshakes
        do_reset();
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back({24'd0, 8'(i + 1)});
            cycle(1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        end
        idle(2, 1'b1);
        chk("t7_wrap", 32'(words_sent), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
